// File: rtl/stim_sig_harness.sv
// stim_sig_harness
// ----------------
// Stimulus sequencer and response compactor for differential fuzzing.
// A seeded xorshift64 generator produces one vector per run step. Each vector
// is held on 'stim' for HOLD clocks. On the final hold clock the DUT
// response is folded into a 32-bit CRC-style signature. At the end of a run
// the signature is compared against 'golden'.
//
// Optional feature macro: STIM_GAP_EN
//   defined   -> GAP zero-vector clocks follow every vector except the last
//   undefined -> vectors are driven back to back; GAP is ignored
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a run (honoured in IDLE and DONE only)
//   abort      in   terminate the run, return to IDLE
//   seed       in   64-bit generator seed, latched on an accepted start
//   golden     in   expected 32-bit signature
//   resp       in   DUT response (RESP_W bits)
//   stim       out  DUT input vector (STIM_W bits), 0 outside DRIVE
//   busy       out  high in DRIVE and GAP
//   vec_idx    out  index of the current vector
//   cap_valid  out  high during the clock whose closing edge captures resp
//   sig        out  running signature
//   done       out  high in DONE
//   pass       out  high in DONE when sig == golden
module stim_sig_harness #(
  parameter int STIM_W = 68,
  parameter int RESP_W = 117,
  parameter int NVEC   = 32,
  parameter int HOLD   = 2,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [63:0]       seed,
  input  logic [31:0]       golden,
  input  logic [RESP_W-1:0] resp,
  output logic [STIM_W-1:0] stim,
  output logic              busy,
  output logic [7:0]        vec_idx,
  output logic              cap_valid,
  output logic [31:0]       sig,
  output logic              done,
  output logic              pass
);

  localparam int          HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int          RESP_CH   = (RESP_W + 31) / 32;
  localparam logic [7:0]  VEC_LAST  = 8'(NVEC - 1);
  localparam logic [63:0] SEED_ALT  = 64'h9E3779B97F4A7C15;
  localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;

`ifdef STIM_GAP_EN
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StGap   = 2'd2,
    StDone  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StDone  = 2'd3
  } state_t;
`endif

  state_t              state_q;
  logic [63:0]         genState_q;
  logic [31:0]         sig_q;
  logic [7:0]          vecIdx_q;
  logic [HOLD_W-1:0]   holdCnt_q;
`ifdef STIM_GAP_EN
  logic [GAP_W-1:0]    gapCnt_q;
`endif

  logic [63:0]         genStep1;
  logic [63:0]         genStep2;
  logic [63:0]         genState_d;
  logic [31:0]         sig_d;
  logic [31:0]         respFold;
  logic [RESP_CH*32-1:0] respExt;
  logic [STIM_W-1:0]   stimVec;
  logic                lastHold;

  // Fold the response into 32 bits by XOR-ing every 32-bit chunk of the
  // zero-extended response together.
  always_comb begin
    respExt = '0;
    respExt[RESP_W-1:0] = resp;
    respFold = '0;
    for (int c = 0; c < RESP_CH; c++) begin
      respFold = respFold ^ respExt[c*32 +: 32];
    end
  end

  // xorshift64 successor of the generator and the next signature value;
  // both are only committed on the final hold clock of a vector.
  assign genStep1   = genState_q ^ (genState_q << 13);
  assign genStep2   = genStep1 ^ (genStep1 >> 7);
  assign genState_d = genStep2 ^ (genStep2 << 17);
  assign sig_d      = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? CRC_POLY : 32'h0) ^ respFold;

  // The vector is the generator state repeated as often as needed to fill
  // STIM_W bits, taking the low bits first.
  always_comb begin
    stimVec = '0;
    for (int i = 0; i < STIM_W; i++) begin
      stimVec[i] = genState_q[i % 64];
    end
  end

  assign lastHold = (state_q == StDrive) && (holdCnt_q == HOLD_W'(HOLD - 1));

  // Outputs are decoded from registered state only, so resp never reaches
  // sig combinationally and pass depends on sig and golden alone.
  assign stim      = (state_q == StDrive) ? stimVec : '0;
`ifdef STIM_GAP_EN
  assign busy      = (state_q == StDrive) || (state_q == StGap);
`else
  assign busy      = (state_q == StDrive);
`endif
  assign cap_valid = lastHold;
  assign vec_idx   = vecIdx_q;
  assign sig       = sig_q;
  assign done      = (state_q == StDone);
  assign pass      = done && (sig_q == golden);

  // Run sequencer. Priority is rst, then abort, then the per-state work.
  // Abort keeps sig and vec_idx so a stopped run can still be inspected.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      genState_q <= '0;
      sig_q      <= '0;
      vecIdx_q   <= '0;
      holdCnt_q  <= '0;
`ifdef STIM_GAP_EN
      gapCnt_q   <= '0;
`endif
    end else if (abort) begin
      state_q    <= StIdle;
      holdCnt_q  <= '0;
`ifdef STIM_GAP_EN
      gapCnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q    <= StDrive;
            genState_q <= (seed == 64'h0) ? SEED_ALT : seed;
            sig_q      <= '0;
            vecIdx_q   <= '0;
            holdCnt_q  <= '0;
          end
        end
        StDrive: begin
          if (lastHold) begin
            sig_q      <= sig_d;
            genState_q <= genState_d;
            holdCnt_q  <= '0;
            if (vecIdx_q == VEC_LAST) begin
              state_q <= StDone;
            end else begin
              vecIdx_q <= vecIdx_q + 8'd1;
`ifdef STIM_GAP_EN
              state_q  <= StGap;
              gapCnt_q <= '0;
`endif
            end
          end else begin
            holdCnt_q <= holdCnt_q + HOLD_W'(1);
          end
        end
`ifdef STIM_GAP_EN
        StGap: begin
          if (gapCnt_q == GAP_W'(GAP - 1)) begin
            state_q  <= StDrive;
            gapCnt_q <= '0;
          end else begin
            gapCnt_q <= gapCnt_q + GAP_W'(1);
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
